// File: rtl/ps2_key_if.sv
// Decoded-key bus from the PS/2 keyboard decoder to the maze movement logic.
interface ps2_key_if;
  logic [7:0] key_code;
  logic       key_valid;
  logic [7:0] scan_byte;
  logic       scan_strobe;
  logic       frame_err;

  modport master (
    output key_code,
    output key_valid,
    output scan_byte,
    output scan_strobe,
    output frame_err
  );

  modport slave (
    input key_code,
    input key_valid,
    input scan_byte,
    input scan_strobe,
    input frame_err
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and scan-code set 2 make/break/E0 decoder.
// Define PS2_KEYPAD_ARROWS_EN to fold keypad 4/6/8/2 onto the arrow-key codes.
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  ps2_key_if.master  key_bus
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // Odd parity across the data byte and its parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  logic          clk_meta_r, clk_sync_r, data_meta_r, data_sync_r;
  logic          clk_filt_r;
  logic [FW-1:0] filt_cnt_r;
  logic          fall_s;
  state_t        state_r, state_nxt_s;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic          parity_r;
  logic [TW-1:0] tmo_cnt_r;
  logic          timeout_s, frame_good_s, frame_bad_s, load_bit_s, load_par_s, start_s;
  logic          ext_r, brk_r, ext_nxt_s, brk_nxt_s, kp_ext_s;
  logic [7:0]    key_code_r, key_nxt_s, k_s;
  logic          key_valid_r, valid_nxt_s;
  logic [7:0]    scan_byte_r;
  logic          scan_strobe_r, frame_err_r;

  // Two-flop synchronizers for both pins; idle bus level is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= ps2_clk;
      clk_sync_r  <= clk_meta_r;
      data_meta_r <= ps2_data;
      data_sync_r <= data_meta_r;
    end
  end

  // Glitch filter: the level flips on the FILTER_LEN-th consecutive differing sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_filt_r <= 1'b1;
      filt_cnt_r <= '0;
    end else if (clk_sync_r != clk_filt_r) begin
      if (filt_cnt_r == FW'(FILTER_LEN - 1)) begin
        clk_filt_r <= clk_sync_r;
        filt_cnt_r <= '0;
      end else begin
        filt_cnt_r <= filt_cnt_r + 1'b1;
      end
    end else begin
      filt_cnt_r <= '0;
    end
  end

  assign fall_s    = clk_filt_r && !clk_sync_r && (filt_cnt_r == FW'(FILTER_LEN - 1));
  assign timeout_s = (state_r != ST_IDLE) && !fall_s && (tmo_cnt_r == TW'(TIMEOUT_CYCLES));

  // Frame FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Frame FSM next state; only fall events or a timeout move it.
  always_comb begin
    state_nxt_s  = state_r;
    frame_good_s = 1'b0;
    frame_bad_s  = 1'b0;
    load_bit_s   = 1'b0;
    load_par_s   = 1'b0;
    start_s      = 1'b0;
    if (timeout_s) begin
      state_nxt_s = ST_IDLE;
      frame_bad_s = 1'b1;
    end else if (fall_s) begin
      case (state_r)
        ST_IDLE: begin
          if (!data_sync_r) begin
            state_nxt_s = ST_DATA;
            start_s     = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_DATA: begin
          load_bit_s = 1'b1;
          if (bit_cnt_r == 3'd7) begin
            state_nxt_s = ST_PARITY;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end
        ST_PARITY: begin
          load_par_s  = 1'b1;
          state_nxt_s = ST_STOP;
        end
        ST_STOP: begin
          if (data_sync_r && odd_parity_ok(shift_r, parity_r)) begin
            frame_good_s = 1'b1;
          end else begin
            frame_bad_s = 1'b1;
          end
          state_nxt_s = ST_IDLE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Shift register, bit counter, parity capture and inter-edge timeout counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      parity_r  <= 1'b0;
      tmo_cnt_r <= '0;
    end else begin
      if (start_s) begin
        bit_cnt_r <= 3'd0;
      end else if (load_bit_s) begin
        bit_cnt_r <= bit_cnt_r + 3'd1;
        shift_r   <= {data_sync_r, shift_r[7:1]};
      end else if (load_par_s) begin
        parity_r <= data_sync_r;
      end
      if (state_r == ST_IDLE || fall_s) begin
        tmo_cnt_r <= '0;
      end else begin
        tmo_cnt_r <= tmo_cnt_r + 1'b1;
      end
    end
  end

  // Scan-code decode of the byte completed by this cycle's good stop bit.
  always_comb begin
    kp_ext_s    = ext_r;
`ifdef PS2_KEYPAD_ARROWS_EN
    case (shift_r)
      8'h6B, 8'h74, 8'h75, 8'h72: kp_ext_s = 1'b1;
      default:                    kp_ext_s = ext_r;
    endcase
`endif
    k_s         = {kp_ext_s, shift_r[6:0]};
    key_nxt_s   = key_code_r;
    valid_nxt_s = key_valid_r;
    ext_nxt_s   = ext_r;
    brk_nxt_s   = brk_r;
    if (timeout_s) begin
      ext_nxt_s = 1'b0;
      brk_nxt_s = 1'b0;
    end else if (frame_good_s) begin
      if (shift_r == 8'hE0) begin
        ext_nxt_s = 1'b1;
      end else if (shift_r == 8'hF0) begin
        brk_nxt_s = 1'b1;
      end else if (shift_r[7]) begin
        ext_nxt_s = 1'b0;
        brk_nxt_s = 1'b0;
      end else begin
        if (!brk_r) begin
          key_nxt_s   = k_s;
          valid_nxt_s = 1'b1;
        end else if (k_s == key_code_r) begin
          key_nxt_s   = 8'h00;
          valid_nxt_s = 1'b0;
        end else begin
          key_nxt_s   = key_code_r;
        end
        ext_nxt_s = 1'b0;
        brk_nxt_s = 1'b0;
      end
    end else begin
      key_nxt_s = key_code_r;
    end
  end

  // Registered outputs and prefix flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ext_r         <= 1'b0;
      brk_r         <= 1'b0;
      key_code_r    <= 8'h00;
      key_valid_r   <= 1'b0;
      scan_byte_r   <= 8'h00;
      scan_strobe_r <= 1'b0;
      frame_err_r   <= 1'b0;
    end else begin
      ext_r         <= ext_nxt_s;
      brk_r         <= brk_nxt_s;
      key_code_r    <= key_nxt_s;
      key_valid_r   <= valid_nxt_s;
      scan_strobe_r <= frame_good_s;
      frame_err_r   <= frame_bad_s;
      if (frame_good_s) begin
        scan_byte_r <= shift_r;
      end else begin
        scan_byte_r <= scan_byte_r;
      end
    end
  end

  assign key_bus.key_code    = key_code_r;
  assign key_bus.key_valid   = key_valid_r;
  assign key_bus.scan_byte   = scan_byte_r;
  assign key_bus.scan_strobe = scan_strobe_r;
  assign key_bus.frame_err   = frame_err_r;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed self-checking bench for ps2_key_decoder with bit-banged PS/2 frames.
module tb_ps2_key_decoder;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   strobe_cnt = 0;
  int   err_cnt = 0;
  int   both_cnt = 0;
  int   glitch_cnt = 0;
  logic mon_en = 1'b0;
  logic [7:0] mon_val = 8'h00;
  int   s0, e0;

  ps2_key_if kb ();

  ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(2000)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_bus  (kb.master)
  );

  always #5 clk = ~clk;

  // Pulse and glitch monitors.
  always @(posedge clk) begin
    if (kb.scan_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
    if (kb.frame_err === 1'b1) err_cnt <= err_cnt + 1;
    if (kb.scan_strobe === 1'b1 && kb.frame_err === 1'b1) both_cnt <= both_cnt + 1;
    if (mon_en && kb.key_code !== mon_val) glitch_cnt <= glitch_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sends the first nbits of a frame: start, 8 data LSB first, parity, stop.
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                            input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (25) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (50) @(posedge clk);
      ps2_clk = 1'b1;
      repeat (25) @(posedge clk);
    end
    ps2_data = 1'b1;
    repeat (50) @(posedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11);
  endtask

  initial begin
    // Reset state
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_key_code", kb.key_code, 8'h00);
    chk("rst_key_valid", kb.key_valid, 1'b0);
    chk("rst_scan_byte", kb.scan_byte, 8'h00);
    chk("rst_strobe", kb.scan_strobe, 1'b0);
    chk("rst_err", kb.frame_err, 1'b0);
    reset_n = 1'b1;
    repeat (20) @(posedge clk);

    // Extended make: left arrow
    s0 = strobe_cnt; e0 = err_cnt;
    send(8'hE0);
    send(8'h6B);
    @(negedge clk);
    chk("t1_strobes", strobe_cnt - s0, 2);
    chk("t1_scan_byte", kb.scan_byte, 8'h6B);
    chk("t1_key_code", kb.key_code, 8'hEB);
    chk("t1_key_valid", kb.key_valid, 1'b1);
    chk("t1_no_err", err_cnt - e0, 0);

    // Extended break, then typematic repeats
    send(8'hE0); send(8'hF0); send(8'h6B);
    @(negedge clk);
    chk("t2_brk_key", kb.key_code, 8'h00);
    chk("t2_brk_valid", kb.key_valid, 1'b0);
    send(8'hE0); send(8'h6B);
    @(negedge clk);
    chk("t2_make_key", kb.key_code, 8'hEB);
    mon_val = 8'hEB; mon_en = 1'b1;
    send(8'hE0); send(8'h6B);
    send(8'hE0); send(8'h6B);
    @(negedge clk);
    mon_en = 1'b0;
    chk("t2_repeat_glitch", glitch_cnt, 0);
    chk("t2_repeat_key", kb.key_code, 8'hEB);

    // Rollover: break of a key no longer held is ignored
    send(8'hE0); send(8'h75);
    @(negedge clk);
    chk("t3_up", kb.key_code, 8'hF5);
    send(8'hE0); send(8'h72);
    @(negedge clk);
    chk("t3_down", kb.key_code, 8'hF2);
    mon_val = 8'hF2; mon_en = 1'b1;
    send(8'hE0); send(8'hF0); send(8'h75);
    @(negedge clk);
    mon_en = 1'b0;
    chk("t3_stale_brk_glitch", glitch_cnt, 0);
    chk("t3_stale_brk_valid", kb.key_valid, 1'b1);
    send(8'hE0); send(8'hF0); send(8'h72);
    @(negedge clk);
    chk("t3_release", kb.key_code, 8'h00);

    // Bad parity, then bad stop bit
    s0 = strobe_cnt; e0 = err_cnt;
    send_frame(8'h74, 1'b1, 1'b0, 11);
    @(negedge clk);
    chk("t4_par_err", err_cnt - e0, 1);
    chk("t4_par_strobe", strobe_cnt - s0, 0);
    chk("t4_par_key", kb.key_code, 8'h00);
    s0 = strobe_cnt; e0 = err_cnt;
    send_frame(8'h74, 1'b0, 1'b1, 11);
    @(negedge clk);
    chk("t4_stop_err", err_cnt - e0, 1);
    chk("t4_stop_strobe", strobe_cnt - s0, 0);
    chk("t4_stop_key", kb.key_code, 8'h00);

    // Timeout mid-frame clears the pending E0 prefix
    send(8'hE0);
    e0 = err_cnt;
    send_frame(8'h55, 1'b0, 1'b0, 5);
    repeat (2500) @(posedge clk);
    @(negedge clk);
    chk("t5_timeout_err", err_cnt - e0, 1);
    send(8'h1C);
    @(negedge clk);
    chk("t5_ext_cleared", kb.key_code, 8'h1C);

    // Asynchronous reset mid-frame
    send_frame(8'h29, 1'b0, 1'b0, 5);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_key", kb.key_code, 8'h00);
    chk("t6_rst_valid", kb.key_valid, 1'b0);
    chk("t6_rst_scan", kb.scan_byte, 8'h00);
    repeat (5) @(posedge clk);
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    send(8'h29);
    @(negedge clk);
    chk("t6_key_29", kb.key_code, 8'h29);
    chk("t6_valid_29", kb.key_valid, 1'b1);
    send(8'h6B);
    @(negedge clk);
`ifdef PS2_KEYPAD_ARROWS_EN
    chk("t6_keypad4", kb.key_code, 8'hEB);
`else
    chk("t6_keypad4", kb.key_code, 8'h6B);
`endif

    chk("strobe_err_overlap", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Receives PS/2 keyboard frames from the board connector and decodes scan-code set 2 make/break/extended sequences.
- Outputs the currently held key as an 8-bit `key_code`: bit 7 is the extended (E0) flag, bits 6:0 are the base scan code.
- Sits between the PS/2 pins and the maze movement logic; arrow keys appear as 0xEB (left), 0xF4 (right), 0xF5 (up), 0xF2 (down).

Parameters:
- FILTER_LEN, 8: consecutive equal samples required before the filtered ps2_clk level changes.
- TIMEOUT_CYCLES, 50_000: clk cycles allowed between falling edges inside a frame before the frame is aborted.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ps2_clk  in  1  PS/2 clock pin (asynchronous)
- ps2_data  in  1  PS/2 data pin (asynchronous)
- key_code  out  8  currently held key {ext, code[6:0]}; 0x00 when none
- key_valid  out  1  high while key_code holds a pressed key
- scan_byte  out  8  last correctly received raw byte
- scan_strobe  out  1  one-cycle pulse per correctly received byte
- frame_err  out  1  one-cycle pulse on parity, stop or timeout error

Behaviour:
- Reset (async, reset_n=0): all outputs 0; FSM in IDLE; prefix flags, filter and counters cleared. A reset asserted mid-frame discards the partial frame.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchronizer.
  - The filtered clock starts at 1 and toggles only after FILTER_LEN consecutive synchronized samples differ from its current value.
  - A filtered 1->0 transition is a "fall" event; ps2_data (synchronized) is sampled on the same cycle.
- Frame FSM, advanced only on fall events:
  - IDLE: data=0 -> DATA with bit count 0; data=1 -> stay in IDLE, no error.
  - DATA: shift data in LSB first; after the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: if data=1 and the 8 data bits plus the parity bit contain an odd number of ones, the frame is good; otherwise frame_err pulses. Either way -> IDLE.
- Timeout:
  - A counter runs in any state other than IDLE and resets on each fall event.
  - When it reaches TIMEOUT_CYCLES: frame_err pulses, FSM -> IDLE, ext/brk prefix flags cleared.
- Good frame, on the cycle after the stop-bit fall event:
  - scan_byte updates and scan_strobe pulses for exactly 1 cycle.
  - Decode of byte b happens in that same cycle; key_code/key_valid change in that cycle.
- Decode rules:
  - b=0xE0: set ext.
  - b=0xF0: set brk.
  - Other b with b[7]=1 (e.g. 0xAA, 0xFA, 0xE1): ignored; ext and brk cleared.
  - Otherwise, with k={ext,b[6:0]}:
    - brk=0 (make): key_code<=k, key_valid<=1. A typematic repeat of the same k leaves the outputs unchanged. A new make replaces the held key.
    - brk=1 (break): if k==key_code, then key_code<=0 and key_valid<=0; a break for any other key is ignored.
    - ext and brk are cleared after either case.
- Error frames never alter key_code, key_valid, ext or brk, except that a timeout clears ext and brk.
- frame_err and scan_strobe are never asserted in the same cycle.

Optional Feature:
- Macro: PS2_KEYPAD_ARROWS_EN.
- Defined: non-extended make/break codes 0x6B, 0x74, 0x75, 0x72 (keypad 4/6/8/2) decode as if ext=1, so keypad keys drive the same key_code values as the arrow keys.
- Undefined: these codes decode with key_code[7]=0 (e.g. 0x6B).

Test Plan (FILTER_LEN=8, TIMEOUT_CYCLES=2000, ps2_clk half-period 50 clk, valid odd parity unless stated):
- Send E0, 6B -> two scan_strobe pulses, scan_byte=0x6B, key_code=0xEB, key_valid=1, frame_err never asserted.
- After the previous test, send E0, F0, 6B -> key_code=0x00, key_valid=0; then E0, 6B repeated 3x -> key_code stays 0xEB with no glitch.
- Send E0, 75, then E0, 72, then E0, F0, 75 -> key_code=0xF2 throughout the 0x75 break; then E0, F0, 72 -> key_code=0x00.
- Send 0x74 with wrong (even) parity -> one frame_err pulse, no scan_strobe, key_code unchanged; repeat with stop bit=0 -> same response.
- Send E0 then abort after 4 data bits, idle 2000+ clk -> one frame_err pulse; then send 0x1C -> key_code=0x1C, proving ext was cleared.
- Pulse reset_n low mid-frame -> all outputs 0 immediately; the next full frame 0x29 -> key_code=0x29; with PS2_KEYPAD_ARROWS_EN defined, 0x6B -> key_code=0xEB.
